// File: rtl/data_mem_resp.sv
// Half-word RAM responder: answers each half access after 1+WAIT_STATES cycles.
// It also reassembles low/high read pairs into a word. Requests are held by the initiator until ready_o.
module data_mem_resp #(
  parameter int          DEPTH_HW    = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int          LP_AW       = $clog2(DEPTH_HW);
  localparam logic [32:0] LP_SPAN     = 33'(2 * DEPTH_HW);
  localparam logic [3:0]  LP_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_re;
  logic        r_we;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_pend;
  logic [31:0] r_pair_addr;
  logic [15:0] r_low;
  logic [15:0] r_rdata;
  logic        r_ready;
  logic        r_err;
  logic [31:0] r_word;
  logic        r_word_valid;
  logic [15:0] r_mem [DEPTH_HW];

  logic             w_idle;
  logic             w_req;
  logic             w_go;
  logic             w_re;
  logic             w_we;
  logic [31:0]      w_addr;
  logic [15:0]      w_wdata;
  logic [31:0]      w_off;
  logic             w_err;
  logic [LP_AW-1:0] w_idx;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_mem_we;
  logic [15:0]      w_ram_q;
  logic             w_pair_hit;
  logic             w_new_low;

  assign w_idle = (r_state == S_IDLE);
  assign w_req  = mem_re_i | mem_we_i;

  // The edge entering RESP is where the RAM is accessed; with no wait states
  // that is the accept edge itself, so the live inputs are used directly.
  assign w_go = (w_idle && w_req && (WAIT_STATES == 0)) ||
                ((r_state == S_WAIT) && (r_cnt == 4'd0));

  assign w_re    = w_idle ? mem_re_i : r_re;
  assign w_we    = w_idle ? mem_we_i : r_we;
  assign w_addr  = w_idle ? addr_i   : r_addr;
  assign w_wdata = w_idle ? wdata_i  : r_wdata;

  assign w_off = w_addr - BASE_ADDR;
  assign w_err = (w_re && w_we) || w_addr[0] || (w_addr < BASE_ADDR) ||
                 ({1'b0, w_off} >= LP_SPAN);
  assign w_idx = w_off[LP_AW:1];

  assign w_rd_ok    = w_re && !w_err;
  assign w_wr_ok    = w_we && !w_err;
  assign w_mem_we   = rst_ni && w_go && w_wr_ok;
  assign w_ram_q    = r_mem[w_idx];
  assign w_pair_hit = r_pend && (w_addr == r_pair_addr + 32'd2);
  assign w_new_low  = w_rd_ok && !w_addr[1];

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_re         <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 16'd0;
      r_pend       <= 1'b0;
      r_pair_addr  <= 32'd0;
      r_low        <= 16'd0;
      r_rdata      <= 16'd0;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_word       <= 32'd0;
      r_word_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_re    <= mem_re_i;
            r_we    <= mem_we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_cnt   <= LP_CNT_INIT;
            r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b0;
          r_err        <= 1'b0;
          r_rdata      <= 16'd0;
          r_word_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_go) begin
        r_state <= S_RESP;
        r_ready <= 1'b1;
        r_err   <= w_err;
        r_rdata <= w_rd_ok ? w_ram_q : 16'd0;
        if (w_rd_ok && w_pair_hit) begin
          r_word       <= {w_ram_q, r_low};
          r_word_valid <= 1'b1;
          r_pend       <= 1'b0;
        end else begin
          // Anything that does not complete the pair drops it; an aligned read restarts it.
          r_pend <= w_new_low;
          if (w_new_low) begin
            r_low       <= w_ram_q;
            r_pair_addr <= w_addr;
          end
        end
      end
    end
  end

  assign rdata_o      = r_rdata;
  assign ready_o      = r_ready;
  assign err_o        = r_err;
  assign word_o       = r_word;
  assign word_valid_o = r_word_valid;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one instance without wait states, one with three.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst0_n, rst3_n;
  logic        re0, we0, re3, we3;
  logic [31:0] addr0, addr3;
  logic [15:0] wd0, wd3;
  logic [15:0] rd0, rd3;
  logic        rdy0, rdy3, err0, err3, wv0, wv3;
  logic [31:0] word0, word3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH_HW(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst0_n), .mem_re_i(re0), .mem_we_i(we0), .addr_i(addr0),
    .wdata_i(wd0), .rdata_o(rd0), .ready_o(rdy0), .err_o(err0), .word_o(word0),
    .word_valid_o(wv0)
  );

  data_mem_resp #(.DEPTH_HW(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .mem_re_i(re3), .mem_we_i(we3), .addr_i(addr3),
    .wdata_i(wd3), .rdata_o(rd3), .ready_o(rdy3), .err_o(err3), .word_o(word3),
    .word_valid_o(wv3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic re, input logic we,
                       input logic [31:0] addr, input logic [15:0] wd);
    if (sel == 0) begin
      re0 = re; we0 = we; addr0 = addr; wd0 = wd;
    end else begin
      re3 = re; we3 = we; addr3 = addr; wd3 = wd;
    end
  endtask

  // One request, held until ready; checks latency, single-cycle pulse and response fields.
  task automatic access(input int sel, input string tag, input logic re, input logic we,
                        input logic [31:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input logic exp_err,
                        input logic exp_wv, input logic [31:0] exp_word);
    int          lat;
    logic [15:0] rd;
    logic        er, wv, rdy_after;
    logic [31:0] wo;
    lat = 0; rd = '0; er = 1'b0; wv = 1'b0; wo = '0;
    @(negedge clk);
    drive(sel, re, we, addr, wd);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if ((sel == 0) ? rdy0 : rdy3) begin
        lat = k;
        rd  = (sel == 0) ? rd0   : rd3;
        er  = (sel == 0) ? err0  : err3;
        wv  = (sel == 0) ? wv0   : wv3;
        wo  = (sel == 0) ? word0 : word3;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 16'h0);
    @(posedge clk); #1;
    rdy_after = (sel == 0) ? rdy0 : rdy3;
    chk({tag, " latency"}, 64'(lat), (sel == 0) ? 64'd1 : 64'd4);
    chk({tag, " pulse"}, 64'(rdy_after), 64'd0);
    chk({tag, " rdata"}, 64'(rd), 64'(exp_rd));
    chk({tag, " err"}, 64'(er), 64'(exp_err));
    chk({tag, " word_valid"}, 64'(wv), 64'(exp_wv));
    if (exp_wv) chk({tag, " word"}, 64'(wo), 64'(exp_word));
  endtask

  // Request held high for 20 cycles: ready at cycle W, then every 2+W.
  task automatic b2b(input int sel, input int w);
    logic [19:0] seen, exp;
    seen = '0; exp = '0;
    for (int i = 0; i < 20; i++)
      if (i >= w && ((i - w) % (2 + w)) == 0) exp[i] = 1'b1;
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, 32'h10, 16'h0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      seen[i] = (sel == 0) ? rdy0 : rdy3;
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 16'h0);
    repeat (6) @(posedge clk);
    chk((sel == 0) ? "b2b ws0" : "b2b ws3", 64'(seen), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1);
  end

  initial begin
    logic any_rdy;
    rst0_n = 1'b0; rst3_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 16'h0);
    drive(3, 1'b0, 1'b0, 32'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ws0 outputs", 64'({rdy0, err0, wv0, rd0, word0}), 64'd0);
    chk("reset ws3 outputs", 64'({rdy3, err3, wv3, rd3, word3}), 64'd0);
    @(negedge clk);
    rst0_n = 1'b1; rst3_n = 1'b1;

    // Word write/read with pair assembly
    access(0, "wr 10",  1'b0, 1'b1, 32'h10, 16'hBEEF, 16'h0,    1'b0, 1'b0, 32'h0);
    access(0, "wr 12",  1'b0, 1'b1, 32'h12, 16'hDEAD, 16'h0,    1'b0, 1'b0, 32'h0);
    access(0, "rd 10",  1'b1, 1'b0, 32'h10, 16'h0,    16'hBEEF, 1'b0, 1'b0, 32'h0);
    access(0, "rd 12",  1'b1, 1'b0, 32'h12, 16'h0,    16'hDEAD, 1'b0, 1'b1, 32'hDEADBEEF);

    // Misaligned and out-of-range errors
    access(0, "rd 10b", 1'b1, 1'b0, 32'h10, 16'h0,    16'hBEEF, 1'b0, 1'b0, 32'h0);
    access(0, "rd 11",  1'b1, 1'b0, 32'h11, 16'h0,    16'h0,    1'b1, 1'b0, 32'h0);
    access(0, "rd 12b", 1'b1, 1'b0, 32'h12, 16'h0,    16'hDEAD, 1'b0, 1'b0, 32'h0);
    access(0, "wr 0",   1'b0, 1'b1, 32'h0,   16'h1111, 16'h0,   1'b0, 1'b0, 32'h0);
    access(0, "wr 7fe", 1'b0, 1'b1, 32'h7FE, 16'h2222, 16'h0,   1'b0, 1'b0, 32'h0);
    access(0, "wr 800", 1'b0, 1'b1, 32'h800, 16'h9999, 16'h0,   1'b1, 1'b0, 32'h0);
    access(0, "rd 0",   1'b1, 1'b0, 32'h0,   16'h0,    16'h1111, 1'b0, 1'b0, 32'h0);
    access(0, "rd 7fe", 1'b1, 1'b0, 32'h7FE, 16'h0,    16'h2222, 1'b0, 1'b0, 32'h0);

    // Pair broken by an intervening write and by a non-adjacent read
    access(0, "wr 20",  1'b0, 1'b1, 32'h20, 16'h1234, 16'h0,    1'b0, 1'b0, 32'h0);
    access(0, "wr 22",  1'b0, 1'b1, 32'h22, 16'h5678, 16'h0,    1'b0, 1'b0, 32'h0);
    access(0, "wr 24",  1'b0, 1'b1, 32'h24, 16'h9ABC, 16'h0,    1'b0, 1'b0, 32'h0);
    access(0, "wr 26",  1'b0, 1'b1, 32'h26, 16'hDEF0, 16'h0,    1'b0, 1'b0, 32'h0);
    access(0, "rd 20",  1'b1, 1'b0, 32'h20, 16'h0,    16'h1234, 1'b0, 1'b0, 32'h0);
    access(0, "wr 40",  1'b0, 1'b1, 32'h40, 16'h4040, 16'h0,    1'b0, 1'b0, 32'h0);
    access(0, "rd 22",  1'b1, 1'b0, 32'h22, 16'h0,    16'h5678, 1'b0, 1'b0, 32'h0);
    access(0, "rd 20b", 1'b1, 1'b0, 32'h20, 16'h0,    16'h1234, 1'b0, 1'b0, 32'h0);
    access(0, "rd 24",  1'b1, 1'b0, 32'h24, 16'h0,    16'h9ABC, 1'b0, 1'b0, 32'h0);
    access(0, "rd 26",  1'b1, 1'b0, 32'h26, 16'h0,    16'hDEF0, 1'b0, 1'b1, 32'hDEF09ABC);

    // Read and write together is rejected without writing
    access(0, "rdwr 10", 1'b1, 1'b1, 32'h10, 16'hFFFF, 16'h0,   1'b1, 1'b0, 32'h0);
    access(0, "rd 10c",  1'b1, 1'b0, 32'h10, 16'h0,    16'hBEEF, 1'b0, 1'b0, 32'h0);

    // Wait-state instance: latency, then reset during WAIT of a write
    access(3, "ws3 wr 30", 1'b0, 1'b1, 32'h30, 16'hAAAA, 16'h0,    1'b0, 1'b0, 32'h0);
    access(3, "ws3 rd 30", 1'b1, 1'b0, 32'h30, 16'h0,    16'hAAAA, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive(3, 1'b0, 1'b1, 32'h30, 16'h5555);
    @(posedge clk); #1;
    @(negedge clk);
    rst3_n = 1'b0;
    drive(3, 1'b0, 1'b0, 32'h0, 16'h0);
    @(posedge clk); #1;
    chk("mid-wait reset outputs", 64'({rdy3, err3, wv3, rd3, word3}), 64'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    any_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      any_rdy = any_rdy | rdy3;
    end
    chk("abandoned access ready", 64'(any_rdy), 64'd0);
    access(3, "ws3 rd 30 after reset", 1'b1, 1'b0, 32'h30, 16'h0, 16'hAAAA, 1'b0, 1'b0, 32'h0);

    // Continuous requests
    b2b(0, 0);
    b2b(3, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
